// File: rtl/if_scratchpad_ctrl.sv
// IF scratchpad: circular buffer for one input-feature row plus a sliding-window
// read controller that feeds the convolution datapath and reports handshake status.
module if_scratchpad_ctrl #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_params,
  input  logic [LEN_W-1:0]  if_len,
  input  logic [LEN_W-1:0]  filt_size,
  input  logic [LEN_W-1:0]  stride,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_full,
  input  logic              r_next_IF,
  input  logic              read_data,
  input  logic              clr_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              wait_data,
  output logic              valid_start_addr,
  output logic              at_end_data
);
  localparam int CNT_W = ADDR_W + 1;
  localparam int CW    = ((LEN_W > CNT_W) ? LEN_W : CNT_W) + 2;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, start_ptr, rd_ptr;
  logic [LEN_W-1:0]  offset, row_pos;
  logic [CNT_W-1:0]  count;
  logic              row_active;
  logic [LEN_W-1:0]  if_len_q, filt_q, stride_q;

  logic wr_acc, rd_acc, win_done, last_window;
  logic [ADDR_W-1:0] next_start;

  assign wr_full          = (count == CNT_W'(DEPTH));
  assign wait_data        = !row_active || (CW'(offset) >= CW'(count));
  assign valid_start_addr = row_active && (CW'(count) >= CW'(filt_q));

  assign wr_acc      = wr_en && !wr_full && !rst && !clr_addr;
  assign rd_acc      = read_data && !wait_data && !rst && !clr_addr;
  assign win_done    = (CW'(offset) == (CW'(filt_q) - CW'(1)));
  assign last_window = (CW'(row_pos) + CW'(stride_q) + CW'(filt_q)) > CW'(if_len_q);
  assign at_end_data = rd_acc && last_window && win_done;
  assign next_start  = start_ptr + ADDR_W'(stride_q);

  // Parameters survive clr_addr; only a hard reset drops them.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_len_q <= '0;
      filt_q   <= '0;
      stride_q <= '0;
    end else if (ld_params) begin
      if_len_q <= if_len;
      if (filt_size == '0)                 filt_q <= LEN_W'(1);
      else if (filt_size > LEN_W'(DEPTH))  filt_q <= LEN_W'(DEPTH);
      else                                 filt_q <= filt_size;
      stride_q <= (stride == '0) ? LEN_W'(1) : stride;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_addr) begin
      wr_ptr     <= '0;
      start_ptr  <= '0;
      rd_ptr     <= '0;
      offset     <= '0;
      count      <= '0;
      row_pos    <= '0;
      row_active <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= mem[rd_ptr];
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      // Write and window retirement may coincide; fold both into one update.
      count <= count + CNT_W'(wr_acc) - ((rd_acc && win_done) ? CNT_W'(stride_q) : '0);
      if (rd_acc) begin
        if (win_done) begin
          offset    <= '0;
          start_ptr <= next_start;
          rd_ptr    <= next_start;
          row_pos   <= row_pos + stride_q;
          if (last_window) row_active <= 1'b0;
        end else begin
          offset <= offset + LEN_W'(1);
          rd_ptr <= rd_ptr + ADDR_W'(1);
        end
      end
      if (r_next_IF) begin
        row_active <= 1'b1;
        row_pos    <= '0;
      end
    end
  end
endmodule

// File: tb/tb_if_scratchpad_ctrl.sv
// Scoreboard bench for if_scratchpad_ctrl: expected window elements are queued
// when a scenario is set up and popped whenever rd_valid is seen.
module tb_if_scratchpad_ctrl;
  logic        clk = 1'b0;
  logic        rst, ld_params, wr_en, r_next_IF, read_data, clr_addr;
  logic [7:0]  if_len, filt_size, stride;
  logic [15:0] wr_data, rd_data;
  logic        wr_full, rd_valid, wait_data, valid_start_addr, at_end_data;

  if_scratchpad_ctrl #(.DATA_W(16), .DEPTH(16), .ADDR_W(4), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .ld_params(ld_params), .if_len(if_len),
    .filt_size(filt_size), .stride(stride), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(wr_full), .r_next_IF(r_next_IF), .read_data(read_data),
    .clr_addr(clr_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wait_data(wait_data), .valid_start_addr(valid_start_addr),
    .at_end_data(at_end_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [15:0] q [$];
  int acc = 0, ends = 0, end_idx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor: accepted-read counter, end marker, and scoreboard pop.
  always @(negedge clk) begin
    if (read_data && !wait_data && !rst && !clr_addr) acc++;
    if (at_end_data) begin
      ends++;
      end_idx = acc;
    end
    if (rd_valid) begin
      if (q.size() == 0) chk("rd_unexpected", 32'(rd_data), 32'hdead);
      else chk("rd_data", 32'(rd_data), 32'(q.pop_front()));
    end
  end

  task automatic do_reset();
    rst = 1; ld_params = 0; wr_en = 0; r_next_IF = 0; read_data = 0; clr_addr = 0;
    if_len = 0; filt_size = 0; stride = 0; wr_data = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic ld(input logic [7:0] l, input logic [7:0] f, input logic [7:0] s);
    if_len = l; filt_size = f; stride = s; ld_params = 1;
    @(posedge clk); #1 ld_params = 0;
  endtask

  task automatic rnext();
    r_next_IF = 1;
    @(posedge clk); #1 r_next_IF = 0;
  endtask

  task automatic wr(input logic [15:0] d);
    wr_data = d; wr_en = 1;
    @(posedge clk); #1 wr_en = 0;
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 300) begin
      @(posedge clk); g++;
    end
    #1;
    chk("drain", 32'(q.size()), 0);
  endtask

  initial begin
    int a0, e0;
    logic saw_full;

    // Basic window, also reset state
    do_reset();
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_wait", 32'(wait_data), 1);
    chk("rst_full", 32'(wr_full), 0);
    chk("rst_vsa", 32'(valid_start_addr), 0);
    chk("rst_end", 32'(at_end_data), 0);
    ld(6, 3, 1);
    rnext();
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 3; k++) q.push_back(16'(w + k + 1));
    a0 = acc; e0 = ends;
    for (int i = 1; i <= 6; i++) wr(16'(i));
    read_data = 1;
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("s1_end_count", 32'(ends - e0), 1);
    chk("s1_end_idx", 32'(end_idx - a0), 12);
    chk("s1_wait_after", 32'(wait_data), 1);
    chk("s1_reads", 32'(acc - a0), 12);
    read_data = 0;

    // Starvation
    do_reset();
    ld(10, 3, 1);
    rnext();
    a0 = acc;
    wr(16'hA1);
    chk("s2_vsa1", 32'(valid_start_addr), 0);
    q.push_back(16'hA1);
    read_data = 1;
    @(posedge clk); #1;
    chk("s2_rdv1", 32'(rd_valid), 1);
    chk("s2_wait1", 32'(wait_data), 1);
    @(posedge clk); #1;
    chk("s2_stall", 32'(rd_valid), 0);
    q.push_back(16'hA2);
    wr(16'hA2);
    chk("s2_wait2", 32'(wait_data), 0);
    @(posedge clk); #1;
    chk("s2_rdv2", 32'(rd_valid), 1);
    chk("s2_vsa2", 32'(valid_start_addr), 0);
    read_data = 0;
    wr(16'hA3);
    chk("s2_vsa3", 32'(valid_start_addr), 1);
    drain();
    chk("s2_reads", 32'(acc - a0), 2);

    // Stride and wrap
    do_reset();
    ld(20, 4, 2);
    rnext();
    e0 = ends;
    for (int s = 0; s <= 16; s += 2)
      for (int k = 0; k < 4; k++) q.push_back(16'(16'h100 + s + k));
    saw_full = 0;
    fork
      begin
        int i = 0, g = 0;
        logic full;
        while (i < 20 && g < 300) begin
          wr_data = 16'(16'h100 + i); wr_en = 1;
          @(negedge clk);
          full = wr_full;
          if (wr_full) saw_full = 1;
          @(posedge clk); #1;
          if (!full) i++;
          g++;
        end
        wr_en = 0;
        chk("s3_writes", 32'(i), 20);
      end
      begin
        repeat (20) @(posedge clk);
        #1 read_data = 1;
        drain();
        read_data = 0;
      end
    join
    chk("s3_saw_full", 32'(saw_full), 1);
    chk("s3_end", 32'(ends - e0), 1);

    // Full and overflow (filt 20 clamps to 16)
    do_reset();
    ld(16, 20, 16);
    rnext();
    e0 = ends;
    for (int i = 0; i < 15; i++) wr(16'(16'h200 + i));
    chk("s4_full15", 32'(wr_full), 0);
    chk("s4_vsa15", 32'(valid_start_addr), 0);
    wr(16'h20F);
    chk("s4_full16", 32'(wr_full), 1);
    chk("s4_vsa16", 32'(valid_start_addr), 1);
    wr(16'h2FF);
    chk("s4_full17", 32'(wr_full), 1);
    for (int i = 0; i < 16; i++) q.push_back(16'(16'h200 + i));
    read_data = 1;
    drain();
    repeat (2) @(posedge clk);
    #1;
    read_data = 0;
    chk("s4_end", 32'(ends - e0), 1);
    chk("s4_full_after", 32'(wr_full), 0);
    chk("s4_wait_after", 32'(wait_data), 1);

    // Simultaneous write and window completion, then clr_addr
    do_reset();
    ld(20, 4, 2);
    rnext();
    for (int i = 0; i < 6; i++) wr(16'(16'h300 + i));
    for (int i = 0; i < 4; i++) q.push_back(16'(16'h300 + i));
    read_data = 1;
    repeat (3) @(posedge clk);
    #1;
    wr_data = 16'h306; wr_en = 1;
    @(posedge clk); #1;
    wr_en = 0; read_data = 0;
    for (int i = 0; i < 10; i++) wr(16'(16'h307 + i));
    chk("s5_full_at15", 32'(wr_full), 0);
    wr(16'h311);
    chk("s5_full_at16", 32'(wr_full), 1);
    drain();
    clr_addr = 1; wr_en = 1; read_data = 1; wr_data = 16'hBAD;
    @(posedge clk); #1;
    clr_addr = 0; wr_en = 0; read_data = 0;
    chk("s5_clr_rdv", 32'(rd_valid), 0);
    chk("s5_clr_full", 32'(wr_full), 0);
    chk("s5_clr_wait", 32'(wait_data), 1);
    chk("s5_clr_vsa", 32'(valid_start_addr), 0);
    ld(1, 1, 1);
    rnext();
    q.push_back(16'h3AA);
    wr(16'h3AA);
    read_data = 1;
    @(posedge clk); #1;
    read_data = 0;
    drain();

    // Reset mid-row
    do_reset();
    ld(6, 3, 1);
    rnext();
    for (int i = 1; i <= 6; i++) wr(16'(i));
    q.push_back(16'd1); q.push_back(16'd2); q.push_back(16'd3); q.push_back(16'd2);
    read_data = 1;
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    chk("s6_rdv", 32'(rd_valid), 0);
    chk("s6_rd_data", 32'(rd_data), 0);
    chk("s6_full", 32'(wr_full), 0);
    chk("s6_vsa", 32'(valid_start_addr), 0);
    chk("s6_end", 32'(at_end_data), 0);
    chk("s6_wait", 32'(wait_data), 1);
    rst = 0;
    wr(16'h55);
    chk("s6_unarmed_wait", 32'(wait_data), 1);
    read_data = 0;
    ld(6, 3, 1);
    rnext();
    chk("s6_rearm_wait", 32'(wait_data), 0);
    chk("s6_rearm_vsa", 32'(valid_start_addr), 0);

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
